// File: rtl/divider_arbiter_pkg.sv
// Shared widths, requester count and FSM encoding for the divider arbiter.
package divider_arbiter_pkg;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int A_W   = 32;
   localparam int B_W   = 16;

   localparam logic [A_W-1:0] DZ_Q = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_e;
endpackage

// File: rtl/divider_arbiter_rr_picker.sv
// Combinational round-robin picker: first active request at or after ptr wins.
module rr_picker
   import divider_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             vld_o
);

   logic [ID_W-1:0] cand;

   // Scan from the farthest offset down so the nearest request to ptr overrides.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr_i + ID_W'(k);
         if (req_i[cand]) begin
            gnt_o       = '0;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            vld_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/divider_arbiter.sv
// Arbitrates four requesters onto one shared multi-cycle divider core,
// short-circuiting divide-by-zero without starting the core.
module divider_arbiter
   import divider_arbiter_pkg::*;
(
   input  logic                   clk,
   input  logic                   clr,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*A_W-1:0]   req_a,
   input  logic [N_REQ*B_W-1:0]   req_b,
   output logic [N_REQ-1:0]       gnt,
   output logic                   resp_valid,
   output logic [ID_W-1:0]        resp_id,
   output logic [A_W-1:0]         resp_q,
   output logic [B_W-1:0]         resp_r,
   output logic                   resp_dz,
   output logic                   div_start,
   output logic [A_W-1:0]         div_a,
   output logic [B_W-1:0]         div_b,
   input  logic [A_W-1:0]         div_q,
   input  logic [B_W-1:0]         div_r,
   input  logic                   div_busy,
   input  logic                   div_ready
);

   state_e          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [A_W-1:0]  a_q, a_d;
   logic [B_W-1:0]  b_q, b_d;
   logic [ID_W-1:0] rid_q, rid_d;
   logic [A_W-1:0]  rq_q, rq_d;
   logic [B_W-1:0]  rr_q, rr_d;
   logic            rdz_q, rdz_d;

   logic [N_REQ-1:0] pick_gnt;
   logic [ID_W-1:0]  pick_idx;
   logic             pick_vld;

   logic [A_W-1:0] a_arr [N_REQ];
   logic [B_W-1:0] b_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[g*A_W +: A_W];
      assign b_arr[g] = req_b[g*B_W +: B_W];
   end

   rr_picker u_picker (
      .req_i (req),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .vld_o (pick_vld)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      id_d       = id_q;
      a_d        = a_q;
      b_d        = b_q;
      rid_d      = rid_q;
      rq_d       = rq_q;
      rr_d       = rr_q;
      rdz_d      = rdz_q;
      gnt        = '0;
      div_start  = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         IDLE: begin
            // gnt is combinational, so it is held off while clr is asserted.
            if (pick_vld && !clr) begin
               gnt  = pick_gnt;
               id_d = pick_idx;
               a_d  = a_arr[pick_idx];
               b_d  = b_arr[pick_idx];
               if (b_d == '0) begin
                  state_d = DONE;
                  rid_d   = pick_idx;
                  rq_d    = DZ_Q;
                  rr_d    = a_d[B_W-1:0];
                  rdz_d   = 1'b1;
               end else begin
                  state_d = LAUNCH;
               end
            end
         end
         LAUNCH: begin
            div_start = 1'b1;
            state_d   = WAIT;
         end
         WAIT: begin
            // The core drops ready on the start edge, so the LAUNCH-cycle ready never lands here.
            if (div_ready && !div_busy) begin
               state_d = DONE;
               rid_d   = id_q;
               rq_d    = div_q;
               rr_d    = div_r;
               rdz_d   = 1'b0;
            end
         end
         DONE: begin
            resp_valid = 1'b1;
            ptr_d      = id_q + ID_W'(1);
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rid_q   <= '0;
         rq_q    <= '0;
         rr_q    <= '0;
         rdz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rid_q   <= rid_d;
         rq_q    <= rq_d;
         rr_q    <= rr_d;
         rdz_q   <= rdz_d;
      end
   end

   assign div_a   = a_q;
   assign div_b   = b_q;
   assign resp_id = rid_q;
   assign resp_q  = rq_q;
   assign resp_r  = rr_q;
   assign resp_dz = rdz_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a 32-cycle behavioural divider core
// and a scoreboard of expected responses.
module tb_divider_arbiter;

   logic         clk = 1'b0;
   logic         clr;
   logic [3:0]   req;
   logic [127:0] req_a;
   logic [63:0]  req_b;
   logic [3:0]   gnt;
   logic         resp_valid;
   logic [1:0]   resp_id;
   logic [31:0]  resp_q;
   logic [15:0]  resp_r;
   logic         resp_dz;
   logic         div_start;
   logic [31:0]  div_a;
   logic [15:0]  div_b;
   logic [31:0]  div_q;
   logic [15:0]  div_r;
   logic         div_busy;
   logic         div_ready;

   divider_arbiter dut (
      .clk        (clk),
      .clr        (clr),
      .req        (req),
      .req_a      (req_a),
      .req_b      (req_b),
      .gnt        (gnt),
      .resp_valid (resp_valid),
      .resp_id    (resp_id),
      .resp_q     (resp_q),
      .resp_r     (resp_r),
      .resp_dz    (resp_dz),
      .div_start  (div_start),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_q      (div_q),
      .div_r      (div_r),
      .div_busy   (div_busy),
      .div_ready  (div_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural core: busy for 32 cycles after start, ready held until next start.
   logic [31:0] core_a;
   logic [15:0] core_b;
   int          core_cnt;
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         div_busy  <= 1'b0;
         div_ready <= 1'b0;
         div_q     <= '0;
         div_r     <= '0;
         core_cnt  <= 0;
         core_a    <= '0;
         core_b    <= '0;
      end else if (div_start) begin
         div_busy  <= 1'b1;
         div_ready <= 1'b0;
         core_cnt  <= 32;
         core_a    <= div_a;
         core_b    <= div_b;
      end else if (div_busy) begin
         core_cnt <= core_cnt - 1;
         if (core_cnt == 1) begin
            div_busy  <= 1'b0;
            div_ready <= 1'b1;
            div_q     <= (core_b == 0) ? 32'hFFFF_FFFF : core_a / {16'd0, core_b};
            div_r     <= (core_b == 0) ? core_a[15:0] : 16'(core_a % {16'd0, core_b});
         end
      end
   end

   typedef struct {
      logic [1:0]  id;
      logic [31:0] a;
      logic [15:0] b;
      logic [31:0] q;
      logic [15:0] r;
      logic        dz;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   gq[$];
   int   checks = 0;
   int   failures = 0;
   int   inflight = 0;
   int   last_resp_cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] id, input logic [31:0] a, input logic [15:0] b);
      exp_t e;
      e.id = id;
      e.a  = a;
      e.b  = b;
      if (b == 0) begin
         e.q   = 32'hFFFF_FFFF;
         e.r   = a[15:0];
         e.dz  = 1'b1;
         e.lat = 1;
      end else begin
         e.q   = a / {16'd0, b};
         e.r   = 16'(a % {16'd0, b});
         e.dz  = 1'b0;
         e.lat = 35;
      end
      return e;
   endfunction

   task automatic set_op(input int i, input logic [31:0] a, input logic [15:0] b);
      req_a[i*32 +: 32] = a;
      req_b[i*16 +: 16] = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input logic [3:0] exp, input string tag);
      int n = 0;
      @(negedge clk);
      while (gnt == 4'd0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, gnt, exp);
   endtask

   task automatic wait_resp(input string tag);
      int n = 0;
      @(negedge clk);
      while (!resp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, resp_valid, 1'b1);
   endtask

   // Response and protocol monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!clr) begin
         if (gnt != 4'd0) begin
            chk("gnt_onehot", $onehot(gnt), 1'b1);
            chk("gnt_overlap", inflight, 0);
            gq.push_back(cyc);
            inflight = 1;
         end
         if (div_start) begin
            if (sb.size() == 0) chk("div_start_unexpected", div_start, 1'b0);
            else begin
               chk("div_start_on_dz", div_start, !sb[0].dz);
               chk("div_start_lat", cyc - gq[$], 1);
               chk("div_a", div_a, sb[0].a);
               chk("div_b", div_b, sb[0].b);
            end
         end
         if (resp_valid) begin
            if (sb.size() == 0 || gq.size() == 0) chk("resp_unexpected", resp_valid, 1'b0);
            else begin
               exp_t e;
               int   g;
               e = sb.pop_front();
               g = gq.pop_front();
               chk("resp_id", resp_id, e.id);
               chk("resp_q", resp_q, e.q);
               chk("resp_r", resp_r, e.r);
               chk("resp_dz", resp_dz, e.dz);
               chk("resp_latency", cyc - g, e.lat);
            end
            inflight = 0;
            last_resp_cyc = cyc;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] order [5];
      clr   = 1'b1;
      req   = 4'd0;
      req_a = '0;
      req_b = '0;
      #12;
      chk("rst_gnt", gnt, 4'd0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_id", resp_id, 2'd0);
      chk("rst_resp_q", resp_q, 32'd0);
      chk("rst_resp_r", resp_r, 16'd0);
      chk("rst_resp_dz", resp_dz, 1'b0);
      chk("rst_div_start", div_start, 1'b0);
      chk("rst_div_a", div_a, 32'd0);
      chk("rst_div_b", div_b, 16'd0);

      // Single normal op, requested on the same cycle reset is released.
      step();
      clr = 1'b0;
      set_op(0, 32'd100, 16'd7);
      req = 4'b0001;
      sb.push_back(mk(2'd0, 32'd100, 16'd7));
      @(negedge clk);
      chk("s1_first_edge_gnt", gnt, 4'b0001);
      step();
      req = 4'd0;
      wait_resp("s1_resp");
      chk("s1_q_const", resp_q, 32'd14);
      chk("s1_r_const", resp_r, 16'd2);

      // Reset returns ptr to 0, so a held 1111 starts at requester 0.
      step();
      clr = 1'b1;
      #2;
      clr = 1'b0;
      set_op(0, 32'd30, 16'd3);
      set_op(1, 32'd31, 16'd3);
      set_op(2, 32'd32, 16'd3);
      set_op(3, 32'd33, 16'd3);
      order[0] = 4'b0001;
      order[1] = 4'b0010;
      order[2] = 4'b0100;
      order[3] = 4'b1000;
      order[4] = 4'b0001;
      for (int i = 0; i < 5; i++) sb.push_back(mk(2'(i % 4), 32'd30 + 32'(i % 4), 16'd3));
      step();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_gnt(order[i], "s2_gnt_order");
         if (i > 0) chk("s2_regrant_gap", cyc - last_resp_cyc, 1);
      end
      step();
      req = 4'd0;
      wait_resp("s2_last_resp");

      // Divide-by-zero bypasses the core.
      set_op(2, 32'h1234_5678, 16'd0);
      step();
      req = 4'b0100;
      sb.push_back(mk(2'd2, 32'h1234_5678, 16'd0));
      wait_gnt(4'b0100, "s3_gnt");
      step();
      req = 4'd0;
      chk("s3_no_start", div_start, 1'b0);
      wait_resp("s3_resp");

      // Serve id 3 with boundary operands, then 1001 must go to id 0 first.
      set_op(3, 32'hFFFF_FFFF, 16'd1);
      step();
      req = 4'b1000;
      sb.push_back(mk(2'd3, 32'hFFFF_FFFF, 16'd1));
      wait_gnt(4'b1000, "s5_id3_gnt");
      step();
      req = 4'd0;
      wait_resp("s5_id3_resp");
      set_op(0, 32'd5, 16'hFFFF);
      set_op(3, 32'd1000, 16'd10);
      sb.push_back(mk(2'd0, 32'd5, 16'hFFFF));
      sb.push_back(mk(2'd3, 32'd1000, 16'd10));
      step();
      req = 4'b1001;
      wait_gnt(4'b0001, "s5_first");
      step();
      req = 4'b1000;
      wait_gnt(4'b1000, "s5_second");
      step();
      req = 4'd0;
      wait_resp("s5_resp");

      // Reset ten cycles into WAIT abandons the op.
      set_op(1, 32'd1000, 16'd9);
      sb.push_back(mk(2'd1, 32'd1000, 16'd9));
      step();
      req = 4'b0010;
      wait_gnt(4'b0010, "s4_gnt");
      step();
      req = 4'd0;
      repeat (11) @(posedge clk);
      #1;
      clr = 1'b1;
      #1;
      chk("s4_clr_gnt", gnt, 4'd0);
      chk("s4_clr_resp_valid", resp_valid, 1'b0);
      chk("s4_clr_resp_id", resp_id, 2'd0);
      chk("s4_clr_resp_q", resp_q, 32'd0);
      chk("s4_clr_resp_r", resp_r, 16'd0);
      chk("s4_clr_resp_dz", resp_dz, 1'b0);
      chk("s4_clr_div_start", div_start, 1'b0);
      chk("s4_clr_div_a", div_a, 32'd0);
      chk("s4_clr_div_b", div_b, 16'd0);
      sb.delete();
      gq.delete();
      inflight = 0;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b0;
      set_op(1, 32'd77, 16'd5);
      req = 4'b0010;
      sb.push_back(mk(2'd1, 32'd77, 16'd5));
      @(negedge clk);
      chk("s4_regrant", gnt, 4'b0010);
      step();
      req = 4'd0;
      wait_resp("s4_resp");
      repeat (5) step();
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 The block SHALL have one clock and its reset SHALL be asynchronous and active-high.
REQ-002 Ports SHALL be as follows:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- req  in  4  per-requester request; held high with operands stable until granted.
- req_a  in  128  dividends; requester i drives bits [32i+31:32i].
- req_b  in  64  divisors; requester i drives bits [16i+15:16i].
- gnt  out  4  one-hot, one-cycle pulse; operands are captured on this cycle.
- resp_valid  out  1  one-cycle result pulse, no backpressure.
- resp_id  out  2  index of the requester owning the result.
- resp_q  out  32  quotient.
- resp_r  out  16  remainder.
- resp_dz  out  1  divide-by-zero flag, qualified by resp_valid.
- div_start  out  1  one-cycle start pulse to the shared divider core.
- div_a  out  32  dividend to the core.
- div_b  out  16  divisor to the core.
- div_q  in  32  core quotient.
- div_r  in  16  core remainder.
- div_busy  in  1  core is computing.
- div_ready  in  1  core result is valid; stays high until the next start.

Function
REQ-003 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, DONE.
REQ-004 In IDLE with req != 0, the block SHALL pick the winner round-robin starting from ptr, pulse gnt[winner], and latch the winner's id, a and b.
REQ-005 In IDLE with req == 0, the block SHALL stay in IDLE with gnt = 0.
REQ-006 The IDLE transition SHALL be:
- latched b == 0 -> DONE, with the core not started;
- otherwise -> LAUNCH.
REQ-007 In LAUNCH, div_start SHALL be 1 for exactly one cycle with div_a/div_b equal to the latched operands, then the FSM SHALL go to WAIT.
REQ-008 div_a/div_b SHALL hold the latched operands from LAUNCH until the FSM leaves WAIT.
REQ-009 In WAIT, the FSM SHALL go to DONE on the first cycle with div_ready = 1 and div_busy = 0, capturing div_q/div_r on that cycle.
REQ-010 In WAIT, the stale div_ready of the LAUNCH cycle SHALL never be sampled.
REQ-011 In DONE, resp_valid SHALL be 1 for one cycle, with resp_id equal to the latched id and resp_q/resp_r/resp_dz valid.
REQ-012 On leaving DONE, ptr SHALL be set to (id+1) mod 4 and the FSM SHALL go to IDLE.
REQ-013 For a divide-by-zero: resp_dz = 1, resp_q = 32'hFFFF_FFFF, resp_r = latched a[15:0].
REQ-014 For a normal result, resp_dz SHALL be 0.
REQ-015 Latency SHALL be:
- normal: gnt to resp_valid = (core latency) + 3 cycles, i.e. 35 for the 32-iteration core;
- divide-by-zero: gnt to resp_valid = 1 cycle.
REQ-016 Throughput SHALL be one operation in flight; no new gnt SHALL issue outside IDLE.
REQ-017 A requester SHALL be able to re-request in the IDLE cycle directly following its DONE; it is then lowest priority, because ptr has already advanced.
REQ-018 A requester that deasserts req before being granted SHALL be dropped silently.
REQ-019 req changes while not in IDLE SHALL be ignored.
REQ-020 gnt SHALL never have more than one bit set.
REQ-021 resp_q, resp_r, resp_id and resp_dz SHALL hold their last values outside resp_valid.

Reset
REQ-022 On clr = 1 the block SHALL enter IDLE immediately (asynchronously), with:
- ptr = 0;
- gnt = 0, resp_valid = 0, resp_id = 0, resp_q = 0, resp_r = 0, resp_dz = 0;
- div_start = 0, div_a = 0, div_b = 0.
REQ-023 A reset mid-operation SHALL abandon the operation with no response.
REQ-024 The divider core SHALL share clr.
REQ-025 After reset release, the first grant SHALL be possible on the first rising edge.

Structure
REQ-026 A shared package SHALL hold:
- N_REQ = 4 and ID_W = 2;
- A_W = 32 and B_W = 16;
- the state encoding (IDLE = 0, LAUNCH = 1, WAIT = 2, DONE = 3);
- DZ_Q = 32'hFFFF_FFFF.
REQ-027 One sub-module, rr_picker, SHALL be used: combinational round-robin, taking req[3:0] and ptr[1:0] and returning a one-hot grant and an index.
REQ-028 The divider core SHALL be instantiated outside this block.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- req = 0001, a = 100, b = 7 -> gnt = 0001; div_start one cycle later; resp_valid 35 cycles after gnt; resp_id = 0, q = 14, r = 2, dz = 0.
- req = 1111 held, all b = 3, a = 30/31/32/33 -> grants in order 0, 1, 2, 3, 0; results 10r0, 10r1, 10r2, 11r0; no overlap.
- req = 0100, a = 32'h1234_5678, b = 0 -> resp_valid 1 cycle after gnt; dz = 1, q = FFFF_FFFF, r = 5678; div_start never asserted.
- clr = 1 asserted 10 cycles into WAIT -> all outputs go to 0 at once; no resp_valid; next req = 0010 is granted normally with ptr = 0.
- After serving id 3, req = 1001 -> id 0 granted before id 3.
- Boundary: a = FFFF_FFFF, b = 1 -> q = FFFF_FFFF, r = 0; a = 5, b = FFFF -> q = 0, r = 5.
